// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: funct3 access encodings,
// the access FSM state type and the WAIT-cycle counter width.
package mem_stage_pkg;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;

  // Wide enough for TIMEOUT_CYCLES up to 255.
  localparam int unsigned TimeoutCntW = 8;

  typedef enum logic {
    StIdle,
    StWait
  } state_e;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane formatting: load extraction/extension from the
// read word and store lane replication plus byte enables.
module load_store_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [3:0]  store_be,
  output logic [31:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = '0;
    case (funct3)
      F3Lb:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3Lh:    load_data = {{16{half_sel[15]}}, half_sel};
      F3Lw:    load_data = rdata;
      F3Lbu:   load_data = {24'h0, byte_sel};
      F3Lhu:   load_data = {16'h0, half_sel};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    store_be   = '0;
    store_data = '0;
    case (funct3)
      F3Sb: begin
        store_be   = 4'b0001 << lane;
        store_data = {4{wdata[7:0]}};
      end
      F3Sh: begin
        store_be   = lane[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata[15:0]}};
      end
      F3Sw: begin
        store_be   = 4'b1111;
        store_data = wdata;
      end
      default: begin
        store_be   = '0;
        store_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data-memory handshake, stalls on slow memory,
// aborts on timeout. Define MISALIGN_CHECK_EN to trap misaligned half/word accesses.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] aluResult,
  input  logic [31:0] writeData,
  input  logic [4:0]  rd,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [31:0] readData,
  output logic [31:0] memAddress,
  output logic [4:0]  rd_out,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic        stall,
  output logic        bus_err,
  output logic        misalign
);

  localparam logic [TimeoutCntW-1:0] TimeoutVal = TimeoutCntW'(TIMEOUT_CYCLES);

  state_e                 state_q, state_d;
  logic [TimeoutCntW-1:0] cnt_q, cnt_d;
  logic                   mem_op;
  logic                   misaligned;
  logic                   req;
  logic                   wb_kill;
  logic [31:0]            load_data;
  logic [3:0]             store_be;
  logic [31:0]            store_data;

  assign mem_op = MemRead | MemWrite;

`ifdef MISALIGN_CHECK_EN
  assign misaligned = mem_op &&
                      (((funct3[1:0] == 2'b01) && aluResult[0]) ||
                       ((funct3[1:0] == 2'b10) && (aluResult[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  load_store_align u_align (
    .funct3     (funct3),
    .lane       (aluResult[1:0]),
    .rdata      (dmem_rdata),
    .wdata      (writeData),
    .load_data  (load_data),
    .store_be   (store_be),
    .store_data (store_data)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req      = 1'b0;
    stall    = 1'b0;
    bus_err  = 1'b0;
    misalign = 1'b0;
    wb_kill  = 1'b0;
    if (rst) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (!mem_op) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (misaligned) begin
      misalign = 1'b1;
      wb_kill  = 1'b1;
      state_d  = StIdle;
      cnt_d    = '0;
    end else begin
      case (state_q)
        StIdle: begin
          req = 1'b1;
          if (!dmem_ready) begin
            stall   = 1'b1;
            state_d = StWait;
            cnt_d   = TimeoutCntW'(1);
          end
        end
        StWait: begin
          if (dmem_ready) begin
            req     = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q >= TimeoutVal) begin
            // Abort: drop the request and suppress the writeback.
            bus_err = 1'b1;
            wb_kill = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            req   = 1'b1;
            stall = 1'b1;
            cnt_d = cnt_q + TimeoutCntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dmem_req     = req;
  assign dmem_we      = req & MemWrite;
  assign dmem_addr    = {aluResult[31:2], 2'b00};
  assign dmem_wdata   = store_data;
  assign dmem_be      = (req && MemWrite) ? store_be : 4'b0000;
  assign readData     = MemRead ? load_data : 32'h0;
  assign memAddress   = aluResult;
  assign rd_out       = rd;
  assign RegWrite_out = RegWrite & ~rst & ~wb_kill;
  assign MemtoReg_out = MemtoReg;

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, maximum WAIT cycles before a memory access is aborted.
REQ-002 SHALL have ports, in this order:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- aluResult  in  32  effective address or ALU result.
- writeData  in  32  store data.
- rd  in  5  destination register.
- RegWrite, MemtoReg, MemRead, MemWrite  in  1 each  EX/MEM control.
- funct3  in  3  access size/sign.
- dmem_req, dmem_we  out  1 each  memory request, write enable.
- dmem_addr  out  32  word-aligned address.
- dmem_wdata  out  32  lane-aligned store data.
- dmem_be  out  4  byte enables.
- dmem_rdata  in  32  read data.
- dmem_ready  in  1  access complete.
- readData, memAddress  out  32 each  to MEM/WB register.
- rd_out  out  5  to MEM/WB register.
- RegWrite_out, MemtoReg_out  out  1 each  to MEM/WB register.
- stall  out  1  freeze upstream stages and the MEM/WB load.
- bus_err, misalign  out  1 each  single-cycle fault pulses.

Function
REQ-003 SHALL implement two states: IDLE, WAIT.
REQ-004 SHALL pass non-memory ops (MemRead=MemWrite=0) through combinationally: memAddress=aluResult, rd_out=rd, RegWrite_out=RegWrite, MemtoReg_out=MemtoReg, readData=0, stall=0, dmem_req=0.
REQ-005 SHALL assert dmem_req while a memory op is present in IDLE or WAIT, with dmem_we=MemWrite and dmem_addr={aluResult[31:2],2'b00}.
REQ-006 SHALL complete a memory op with zero stall cycles when dmem_ready=1 in the request cycle; otherwise it SHALL assert stall and enter WAIT.
REQ-007 In WAIT, SHALL hold stall=1 until the cycle dmem_ready=1. In that cycle stall=0, results are valid and the next state is IDLE.
REQ-008 SHALL count WAIT cycles. On reaching TIMEOUT_CYCLES without dmem_ready it SHALL pulse bus_err for 1 cycle, force RegWrite_out=0, drop stall and dmem_req, and return to IDLE.
REQ-009 Loads SHALL format readData from dmem_rdata by funct3 using lane aluResult[1:0]: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend. Any other funct3 SHALL yield readData=0.
REQ-010 Stores SHALL drive dmem_be and dmem_wdata as follows:
- SB: be=4'b0001<<addr[1:0], byte replicated on all 4 lanes.
- SH: be=0011 (addr[1]=0) or 1100 (addr[1]=1), half replicated on both halves.
- SW: be=1111.
REQ-011 A dmem_ready arriving while dmem_req=0 SHALL be ignored.

Reset
REQ-012 While rst=1: state←IDLE and counter←0; dmem_req, stall, bus_err, misalign and RegWrite_out SHALL be 0.
REQ-013 Reset asserted in WAIT SHALL abandon the access with no bus_err and no writeback; the module SHALL be in IDLE in the first cycle after rst falls.

Configuration
REQ-014 Macro MISALIGN_CHECK_EN, when defined, SHALL flag halfword accesses with addr[0]=1 and word accesses with addr[1:0]≠0. For a flagged access: dmem_req=0, misalign pulses 1 cycle, RegWrite_out=0, stall=0.
REQ-015 Without MISALIGN_CHECK_EN, misalign SHALL be tied 0, addr[0] SHALL be ignored for halfwords and addr[1:0] ignored for words.

Structure
REQ-016 Package mem_stage_pkg SHALL hold the funct3 load/store encodings, the IDLE/WAIT state enum and the TIMEOUT counter width constant.
REQ-017 Byte-lane formatting (REQ-009/010) SHALL live in one combinational sub-module, load_store_align.

Verification
REQ-018 LB, addr 0x1003, dmem_rdata 0x80FF_FF00, ready in request cycle → readData 0xFFFF_FF80, stall never 1.
REQ-019 SH, addr 0x2002, writeData 0x0000_BEEF, ready after 3 cycles → be 1100, wdata 0xBEEF_BEEF, stall high exactly 3 cycles.
REQ-020 LW with dmem_ready held 0 → stall high 16 cycles, bus_err pulse, RegWrite_out 0, then back to IDLE.
REQ-021 LW, addr 0x1002, with MISALIGN_CHECK_EN → misalign=1, dmem_req=0; without the macro → dmem_addr 0x1000, normal load.
REQ-022 rst asserted at WAIT cycle 2 of an LHU → no bus_err; the next ADD passes through unstalled with RegWrite_out=1.
